// File: rtl/score_bcd_counter_pkg.sv
// Shared types and constants for the BCD score keeper.
// Used by score_bcd_counter and its per-digit sub-module.
package score_bcd_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      OVER = 2'b10
   } state_t;

   localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
   localparam int          SCORE_DIGITS  = 4;
   localparam logic [15:0] SCORE_MAX     = 16'h9999;

endpackage

// File: rtl/score_bcd_counter_bcd_digit.sv
// One decimal digit of the score: synchronous clear, increment with wrap 9->0.
// carry is combinational so a chain of digits ripples within one cycle.
module score_bcd_counter_bcd_digit
   import score_bcd_counter_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] digit,
   output logic       carry
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         digit <= 4'd0;
      end else if (clr) begin
         digit <= 4'd0;
      end else if (inc) begin
         digit <= (digit == BCD_MAX_DIGIT) ? 4'd0 : digit + 4'd1;
      end
   end

   assign carry = inc && (digit == BCD_MAX_DIGIT);

endmodule

// File: rtl/score_bcd_counter.sv
// Game score keeper: frame divider plus a 4-digit BCD score with milestone pulse.
// Optional high-score register enabled by defining SCORE_HIGH_SCORE_EN.
//
// state | meaning
// IDLE  | powered up, waiting for first start
// RUN   | game in progress, frame ticks advance the score
// OVER  | collision seen, score frozen until next start
module score_bcd_counter
   import score_bcd_counter_pkg::*;
#(
   parameter int FRAMES_PER_POINT = 6,
   parameter int DIV_W            = 4,
   parameter int MILESTONE_DIGIT  = 2
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      frame_tick,
   input  logic                      start,
   input  logic                      game_over,
   output logic [4*SCORE_DIGITS-1:0] score_bcd,
   output logic                      running,
   output logic                      over,
   output logic                      milestone,
   output logic                      saturated
`ifdef SCORE_HIGH_SCORE_EN
   ,
   output logic [4*SCORE_DIGITS-1:0] high_bcd
`endif
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_POINT - 1);

   state_t           state_q;
   state_t           state_d;
   logic [DIV_W-1:0] div_q;
   logic             clr;
   logic             to_over;
   logic             tick_run;
   logic             point;
   logic             milestone_q;
   logic             inc [0:SCORE_DIGITS];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)     state_d = RUN;
         RUN:     if (game_over) state_d = OVER;
         OVER:    if (start)     state_d = RUN;
         default:                state_d = IDLE;
      endcase
   end

   // game_over has priority over both start and frame_tick while running
   assign clr      = ((state_q == IDLE) || (state_q == OVER)) && start;
   assign to_over  = (state_q == RUN) && game_over;
   assign tick_run = (state_q == RUN) && frame_tick && !game_over;
   assign point    = tick_run && (div_q == DIV_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         div_q       <= '0;
         milestone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         milestone_q <= inc[MILESTONE_DIGIT];
         if (clr) begin
            div_q <= '0;
         end else if (tick_run) begin
            div_q <= point ? '0 : div_q + 1'b1;
         end
      end
   end

   assign saturated = (score_bcd == SCORE_MAX);
   assign inc[0]    = point && !saturated;

   for (genvar i = 0; i < SCORE_DIGITS; i++) begin : g_digit
      score_bcd_counter_bcd_digit u_digit (
         .clk    (clk),
         .resetn (resetn),
         .clr    (clr),
         .inc    (inc[i]),
         .digit  (score_bcd[4*i +: 4]),
         .carry  (inc[i+1])
      );
   end

   assign running   = (state_q == RUN);
   assign over      = (state_q == OVER);
   assign milestone = milestone_q;

`ifdef SCORE_HIGH_SCORE_EN
   // packed BCD orders the same as its unsigned value, so a plain compare works
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         high_bcd <= '0;
      end else if (to_over && (score_bcd > high_bcd)) begin
         high_bcd <= score_bcd;
      end
   end
`endif

endmodule

// File: tb/tb_score_bcd_counter.sv
// Self-checking bench for score_bcd_counter: vector table plus scoreboarded reference model.
module tb_score_bcd_counter;

   localparam int FPP = 6;
   localparam int MSD = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        frame_tick;
   logic        start;
   logic        game_over;
   logic [15:0] score_bcd;
   logic        running;
   logic        over;
   logic        milestone;
   logic        saturated;
`ifdef SCORE_HIGH_SCORE_EN
   logic [15:0] high_bcd;
`endif

   score_bcd_counter #(
      .FRAMES_PER_POINT (FPP),
      .DIV_W            (4),
      .MILESTONE_DIGIT  (MSD)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .frame_tick (frame_tick),
      .start      (start),
      .game_over  (game_over),
      .score_bcd  (score_bcd),
      .running    (running),
      .over       (over),
      .milestone  (milestone),
      .saturated  (saturated)
`ifdef SCORE_HIGH_SCORE_EN
      ,
      .high_bcd   (high_bcd)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] outs;
      logic [15:0] high;
   } exp_t;

   typedef struct {
      bit          s;
      bit          g;
      bit          t;
      int          n;
      logic [15:0] score;
      bit          run;
      bit          ovr;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[11];

   int checks = 0;
   int errors = 0;
   int ms_cnt = 0;

   // reference model: 0 idle, 1 run, 2 over
   int m_state = 0;
   int m_div   = 0;
   int m_score = 0;
   int m_high  = 0;
   bit m_ms    = 1'b0;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int pow10(input int e);
      int r = 1;
      for (int k = 0; k < e; k++) r = r * 10;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit s, input bit g, input bit t);
      m_ms = 1'b0;
      case (m_state)
         1: begin
            if (g) begin
               m_state = 2;
               if (m_score > m_high) m_high = m_score;
            end else if (t) begin
               if (m_div == FPP - 1) begin
                  m_div = 0;
                  if (m_score < 9999) begin
                     m_score++;
                     if (m_score % pow10(MSD) == 0) m_ms = 1'b1;
                  end
               end else begin
                  m_div++;
               end
            end
         end
         default: begin
            if (s) begin
               m_state = 1;
               m_score = 0;
               m_div   = 0;
            end
         end
      endcase
   endtask

   task automatic step(input bit s, input bit g, input bit t);
      exp_t e;
      exp_t got;
      start      = s;
      game_over  = g;
      frame_tick = t;
      model_step(s, g, t);
      e.outs = {to_bcd(m_score), m_state == 1, m_state == 2, m_ms, m_score == 9999};
      e.high = to_bcd(m_high);
      sb.push_back(e);
      @(posedge clk);
      #1;
      start      = 1'b0;
      game_over  = 1'b0;
      frame_tick = 1'b0;
      got = sb.pop_front();
      check("outputs", {12'h0, score_bcd, running, over, milestone, saturated}, {12'h0, got.outs});
`ifdef SCORE_HIGH_SCORE_EN
      check("high_bcd", {16'h0, high_bcd}, {16'h0, got.high});
`endif
      if (milestone === 1'b1) ms_cnt++;
   endtask

   task automatic run_ticks(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      //           s  g  t  n   score     run ovr
      vecs[0]  = '{1, 0, 0, 1,  16'h0000, 1, 0};
      vecs[1]  = '{0, 0, 1, 12, 16'h0002, 1, 0};
      vecs[2]  = '{1, 0, 0, 1,  16'h0002, 1, 0};
      vecs[3]  = '{0, 0, 1, 5,  16'h0002, 1, 0};
      vecs[4]  = '{0, 1, 1, 1,  16'h0002, 0, 1};
      vecs[5]  = '{0, 0, 1, 10, 16'h0002, 0, 1};
      vecs[6]  = '{0, 1, 0, 1,  16'h0002, 0, 1};
      vecs[7]  = '{1, 0, 0, 1,  16'h0000, 1, 0};
      vecs[8]  = '{0, 0, 1, 5,  16'h0000, 1, 0};
      vecs[9]  = '{0, 0, 1, 1,  16'h0001, 1, 0};
      vecs[10] = '{1, 1, 0, 1,  16'h0001, 0, 1};

      resetn     = 1'b0;
      start      = 1'b0;
      game_over  = 1'b0;
      frame_tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {12'h0, score_bcd, running, over, milestone, saturated}, 32'h0);
`ifdef SCORE_HIGH_SCORE_EN
      check("reset_high", {16'h0, high_bcd}, 32'h0);
`endif
      @(negedge clk) resetn = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         for (int k = 0; k < vecs[i].n; k++) step(vecs[i].s, vecs[i].g, vecs[i].t);
         check($sformatf("vec%0d", i), {13'h0, score_bcd, running, over},
               {13'h0, vecs[i].score, vecs[i].run, vecs[i].ovr});
      end

`ifdef SCORE_HIGH_SCORE_EN
      step(1'b1, 1'b0, 1'b0);
      run_ticks(150 * FPP);
      step(1'b0, 1'b1, 1'b0);
      check("high_150", {16'h0, high_bcd}, 32'h0150);
      step(1'b1, 1'b0, 1'b0);
      run_ticks(90 * FPP);
      step(1'b0, 1'b1, 1'b0);
      check("high_keep", {16'h0, high_bcd}, 32'h0150);
`endif

      step(1'b1, 1'b0, 1'b0);
      run_ticks(99 * FPP);
      check("score_0099", {16'h0, score_bcd}, 32'h0099);
      ms_cnt = 0;
      run_ticks(FPP);
      check("score_0100", {16'h0, score_bcd}, 32'h0100);
      check("ms_0100", ms_cnt, 1);
      run_ticks(899 * FPP);
      check("score_0999", {16'h0, score_bcd}, 32'h0999);
      ms_cnt = 0;
      run_ticks(FPP);
      check("score_1000", {16'h0, score_bcd}, 32'h1000);
      check("ms_1000", ms_cnt, 1);
      run_ticks(8999 * FPP);
      check("score_9999", {16'h0, score_bcd}, 32'h9999);
      check("saturated", {31'h0, saturated}, 32'h1);
      ms_cnt = 0;
      run_ticks(30);
      check("sat_hold", {16'h0, score_bcd}, 32'h9999);
      check("sat_no_ms", ms_cnt, 0);

      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      run_ticks(42 * FPP);
      check("score_0042", {16'h0, score_bcd}, 32'h0042);
      #2 resetn = 1'b0;
      #1;
      check("async_reset", {13'h0, score_bcd, running, over}, 32'h0);
`ifdef SCORE_HIGH_SCORE_EN
      check("reset_high_clr", {16'h0, high_bcd}, 32'h0);
      m_high = 0;
`endif
      m_state = 0;
      m_div   = 0;
      m_score = 0;
      m_ms    = 1'b0;
      @(negedge clk) resetn = 1'b1;
      @(posedge clk);
      #1;
      run_ticks(FPP + 2);
      check("idle_ticks", {14'h0, score_bcd, running, over}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Game score keeper that sits between the frame-rate timing stage and the seven-segment digit decoders.
- Consumes a one-cycle frame tick (asserted when the 60 FPS delay counter reaches zero) and advances a 4-digit BCD score every FRAMES_PER_POINT frames while the game runs.
- Emits packed BCD digits that drive the HEX display decoders directly, plus a milestone pulse the speed/difficulty logic uses.

Parameters:
- FRAMES_PER_POINT, 6, frame ticks per +1 score; legal range 1..2**DIV_W.
- DIV_W, 4, width of the internal frame divider.
- MILESTONE_DIGIT, 2, BCD digit index whose carry-in raises milestone (2 = every 100 points).

Ports:
- clk  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per displayed frame
- start  in  1  one-cycle pulse: begin or restart a game
- game_over  in  1  one-cycle pulse: collision detected
- score_bcd  out  16  {thousands, hundreds, tens, ones}, 4 bits each, each digit 0..9
- running  out  1  high in RUN
- over  out  1  high in OVER
- milestone  out  1  one-cycle pulse on each MILESTONE_DIGIT carry
- saturated  out  1  high while score == 9999

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, score_bcd=16'h0000, frame divider=0, milestone=0, saturated=0, running=0, over=0.
- States: IDLE (2'b00), RUN (2'b01), OVER (2'b10); 2'b11 is illegal and recovers to IDLE on the next clk.
- IDLE -> RUN on start. The same edge clears score and divider.
- RUN -> OVER on game_over. Score freezes.
- OVER -> RUN on start. The same edge clears score and divider.
- start while in RUN: ignored.
- game_over while in IDLE or OVER: ignored.
- Same cycle in RUN, game_over and frame_tick: game_over wins; no divider or score change.
- Same cycle in RUN, game_over and start: game_over wins.
- Divider in RUN: each frame_tick increments the divider.
- When divider == FRAMES_PER_POINT-1 and frame_tick is high: divider<=0 and score +1 in BCD. The new score is visible on the cycle after the tick edge (1-cycle latency).
- FRAMES_PER_POINT=1: every tick increments the score.
- BCD increment: ones 9->0 with carry into tens, and so on; no digit ever holds A..F.
- Saturation: at 9999 the score holds, saturated=1, and the divider keeps running with no effect.
- milestone is high for exactly the cycle after the increment that produced the carry into MILESTONE_DIGIT (e.g. 0099->0100).
- No milestone when incrementing is blocked by saturation.
- frame_tick outside RUN: no effect. Divider holds at 0.
- running and over are decoded combinationally from the state register.

Optional Feature:
- Macro: SCORE_HIGH_SCORE_EN.
- Defined:
  - Adds output high_bcd [15:0]; reset value 0.
  - On the RUN->OVER edge, high_bcd <= score_bcd if score_bcd > high_bcd. The comparison is digit-wise from the most significant digit, which equals the unsigned compare of the packed vector.
  - high_bcd survives start; only resetn clears it.
- Not defined: no high_bcd port and no high-score register; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encodings IDLE/RUN/OVER;
  - BCD_MAX_DIGIT = 4'd9;
  - SCORE_DIGITS = 4;
  - SCORE_MAX = 16'h9999.
- Natural sub-module: bcd_digit (one instance per digit).
  - Inputs: clk, resetn, clr, inc.
  - Outputs: 4-bit digit, carry (= inc & digit==9).
  - Instances are chained with carry -> next inc.
  - Saturation gating is applied to the ones-digit inc in the parent.

Test Plan:
- Reset mid-RUN at score 0042, resetn low without a clk edge -> score_bcd=0000, running=0, over=0, all immediately.
- start, then 12 frame_ticks (FRAMES_PER_POINT=6) -> score 0002 one cycle after the 12th tick; milestone never asserted.
- Preload to 0099 via ticks, then 6 more ticks -> score 0100 and milestone high for exactly one cycle. Repeat to 0999 -> 1000, with one milestone pulse.
- Run to 9999, then 30 more ticks -> score stays 9999, saturated=1, no milestone.
- game_over and frame_tick in the same cycle at divider=5 -> state OVER, score unchanged. Then start -> RUN, score 0000, divider 0.
- With SCORE_HIGH_SCORE_EN:
  - game over at 0150 -> high_bcd=0150;
  - start, game over at 0090 -> high_bcd stays 0150;
  - resetn low -> high_bcd=0000.
